dmem_responder: RTL



---
 rtl/dmem_pkg.sv | 36 +++
 rtl/dmem_lane_sel.sv | 36 +++
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
// FSM state encodings, strobe-decoded access types and byte-lane indices.
package dmem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [2:0] {
        ACC_RB,
        ACC_RW,
        ACC_WB,
        ACC_WW,
        ACC_BAD
    } acc_t;

    localparam logic [1:0] LANE_0 = 2'd0;
    localparam logic [1:0] LANE_1 = 2'd1;
    localparam logic [1:0] LANE_2 = 2'd2;
    localparam logic [1:0] LANE_3 = 2'd3;

    // Exactly one strobe must be set; anything else is an illegal access.
    function automatic acc_t decode_access(input logic we_b, input logic we_w,
                                           input logic re_b, input logic re_w);
        acc_t acc;
        case ({we_b, we_w, re_b, re_w})
            4'b1000: acc = ACC_WB;
            4'b0100: acc = ACC_WW;
            4'b0010: acc = ACC_RB;
            4'b0001: acc = ACC_RW;
            default: acc = ACC_BAD;
        endcase
        return acc;
    endfunction

endpackage

// File: rtl/dmem_lane_sel.sv
// Byte-lane helper: zero-extended byte extract for reads and single-byte
// merge into an existing word for writes, little-endian lane numbering.
module dmem_lane_sel
    import dmem_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [7:0]  wbyte,
    output logic [31:0] rbyte,
    output logic [31:0] merged
);

    always_comb begin
        rbyte  = '0;
        merged = word;
        unique case (lane)
            LANE_0: begin
                rbyte        = {24'h0, word[7:0]};
                merged[7:0]  = wbyte;
            end
            LANE_1: begin
                rbyte        = {24'h0, word[15:8]};
                merged[15:8] = wbyte;
            end
            LANE_2: begin
                rbyte         = {24'h0, word[23:16]};
                merged[23:16] = wbyte;
            end
            LANE_3: begin
                rbyte         = {24'h0, word[31:24]};
                merged[31:24] = wbyte;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request and programmable wait states.
// Optional access counters are built when DMEM_ACCESS_COUNT_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we_b,
    input  logic        we_w,
    input  logic        re_b,
    input  logic        re_w,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        resp_err
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit          ZERO_LAT = (LATENCY == 0);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, wdata_q;
    logic [3:0]       strb_q;
    logic             resp_valid_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_strb;
    acc_t        acc;
    logic        in_range, misaligned, err;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0] mem_word, lane_rbyte, lane_merged;
    logic [31:0] rdata_d;
    logic        write_en;
    logic [31:0] wr_word;

    assign req_ready = (state_q == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With zero latency the access completes on the accept edge itself, so the
    // live inputs stand in for the not-yet-latched request.
    assign cur_addr  = (state_q == ST_IDLE) ? addr  : addr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? wdata : wdata_q;
    assign cur_strb  = (state_q == ST_IDLE) ? {we_b, we_w, re_b, re_w} : strb_q;

    assign acc        = decode_access(cur_strb[3], cur_strb[2], cur_strb[1], cur_strb[0]);
    assign in_range   = {2'b00, cur_addr[31:2]} < DEPTH_WORDS;
    assign misaligned = ((acc == ACC_RW) || (acc == ACC_WW)) && (cur_addr[1:0] != 2'b00);
    assign err        = (acc == ACC_BAD) || !in_range || misaligned;
    assign mem_idx    = cur_addr[IDX_W+1:2];
    assign mem_word   = mem[mem_idx];

    dmem_lane_sel u_lane_sel (
        .lane   (cur_addr[1:0]),
        .word   (mem_word),
        .wbyte  (cur_wdata[7:0]),
        .rbyte  (lane_rbyte),
        .merged (lane_merged)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ZERO_LAT) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        if (!err) begin
            unique case (acc)
                ACC_RB:  rdata_d = lane_rbyte;
                ACC_RW:  rdata_d = mem_word;
                default: rdata_d = '0;
            endcase
        end
    end

    assign write_en = enter_resp && !err && ((acc == ACC_WB) || (acc == ACC_WW));
    assign wr_word  = (acc == ACC_WW) ? cur_wdata : lane_merged;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= enter_resp;
            rdata_q      <= enter_resp ? rdata_d : 32'h0;
            err_q        <= enter_resp && err;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            strb_q  <= {we_b, we_w, re_b, re_w};
        end
    end

    // Storage is deliberately not reset; reset only blocks an uncommitted write.
    always_ff @(posedge clk) begin
        if (!reset && write_en) begin
            mem[mem_idx] <= wr_word;
        end
    end

    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign resp_err   = err_q;

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (enter_resp && !err) begin
            if ((acc == ACC_RB) || (acc == ACC_RW)) begin
                rd_count <= rd_count + 32'd1;
            end
            if ((acc == ACC_WB) || (acc == ACC_WW)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule
